// File: rtl/prf_free_list_mp_if.sv
// prf_free_list_mp_if
//   Handshake bundle between the rename/retire logic and the multi-port
//   physical-register free list.
//   master : rename/ROB side (drives requests, releases, commits, flush)
//   slave  : free list side (drives ids, grant, free_count, fl_error)
//   Signals:
//     alloc_req    per-lane allocation request
//     alloc_prf_id per-lane allocated id, lane i at [i*PRF_WIDTH +: PRF_WIDTH]
//     alloc_grant  all requested lanes served this cycle
//     commit_cnt   number of allocated ids retired this cycle
//     rel_valid    per-lane release valid
//     rel_prf_id   per-lane released T_old id
//     flush        recovery: restore speculative head from commit head
//     free_count   free entries (speculative view)
//     fl_error     sticky overflow/underflow/commit error
interface prf_free_list_mp_if #(
  parameter int PRF_NUM     = 64,
  parameter int PRF_WIDTH   = 6,
  parameter int ARF_NUM     = 32,
  parameter int ALLOC_PORTS = 2,
  parameter int REL_PORTS   = 2
);
  localparam int PW = $clog2(PRF_NUM - ARF_NUM) + 1;
  localparam int CW = $clog2(ALLOC_PORTS + 1);

  logic [ALLOC_PORTS-1:0]           alloc_req;
  logic [ALLOC_PORTS*PRF_WIDTH-1:0] alloc_prf_id;
  logic                             alloc_grant;
  logic [CW-1:0]                    commit_cnt;
  logic [REL_PORTS-1:0]             rel_valid;
  logic [REL_PORTS*PRF_WIDTH-1:0]   rel_prf_id;
  logic                             flush;
  logic [PW-1:0]                    free_count;
  logic                             fl_error;

  modport master (
    output alloc_req, commit_cnt, rel_valid, rel_prf_id, flush,
    input  alloc_prf_id, alloc_grant, free_count, fl_error
  );

  modport slave (
    input  alloc_req, commit_cnt, rel_valid, rel_prf_id, flush,
    output alloc_prf_id, alloc_grant, free_count, fl_error
  );
endinterface

// File: rtl/prf_free_list_mp.sv
// prf_free_list_mp
//   Multi-port physical-register free list for a superscalar rename stage.
//   A circular list of free PRF ids with three pointers:
//     head        speculative allocation pointer
//     commit_head architectural allocation pointer (advanced by commits)
//     tail        release pointer (T_old ids written here)
//   A flush rewinds head to commit_head in one cycle; list contents between
//   commit_head and the old head are still intact, so those ids are free again.
//   Ports:
//     clk   clock
//     reset asynchronous active-high reset
//     fl    prf_free_list_mp_if.slave bundle (see interface header)
module prf_free_list_mp #(
  parameter int PRF_NUM     = 64,
  parameter int PRF_WIDTH   = 6,
  parameter int ARF_NUM     = 32,
  parameter int ALLOC_PORTS = 2,
  parameter int REL_PORTS   = 2
) (
  input logic               clk,
  input logic               reset,
  prf_free_list_mp_if.slave fl
);
  localparam int DEPTH = PRF_NUM - ARF_NUM;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int AC_W  = $clog2(ALLOC_PORTS + 1);
  localparam int RC_W  = $clog2(REL_PORTS + 1);

  logic [PRF_WIDTH-1:0] fl_mem [DEPTH];

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] commit_head_reg, commit_head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic          fl_error_reg, fl_error_next;

  logic [PW-1:0] free_count;
  logic          grant;

  // Prefix counts: number of active lanes strictly below each lane, which
  // compacts requests/releases onto consecutive list slots.
  logic [AC_W-1:0] alloc_pre [ALLOC_PORTS];
  logic [AC_W-1:0] alloc_cnt;
  logic [RC_W-1:0] rel_pre [REL_PORTS];
  logic [RC_W-1:0] rel_cnt;

  logic [AW-1:0] rd_idx [ALLOC_PORTS];
  logic [AW-1:0] wr_idx [REL_PORTS];

  logic [ALLOC_PORTS*PRF_WIDTH-1:0] alloc_ids;

  always_comb begin
    alloc_cnt = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      alloc_pre[i] = alloc_cnt;
      alloc_cnt    = alloc_cnt + AC_W'(fl.alloc_req[i]);
    end
  end

  always_comb begin
    rel_cnt = '0;
    for (int r = 0; r < REL_PORTS; r++) begin
      rel_pre[r] = rel_cnt;
      rel_cnt    = rel_cnt + RC_W'(fl.rel_valid[r]);
    end
  end

  // Index arithmetic is done at array width so it wraps naturally.
  for (genvar gi = 0; gi < ALLOC_PORTS; gi++) begin : g_rd
    assign rd_idx[gi] = head_reg[AW-1:0] + AW'(alloc_pre[gi]);
  end

  for (genvar gi = 0; gi < REL_PORTS; gi++) begin : g_wr
    assign wr_idx[gi] = tail_reg[AW-1:0] + AW'(rel_pre[gi]);
  end

  always_comb begin
    alloc_ids = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      if (fl.alloc_req[i]) begin
        alloc_ids[i*PRF_WIDTH +: PRF_WIDTH] = fl_mem[rd_idx[i]];
      end
    end
  end

  assign free_count = tail_reg - head_reg;

  // Grant sees free_count before this cycle's releases: no release bypass.
  assign grant = ~fl.flush & ((alloc_cnt == '0) | (free_count >= PW'(alloc_cnt)));

  assign fl.alloc_prf_id = alloc_ids;
  assign fl.alloc_grant  = grant;
  assign fl.free_count   = free_count;
  assign fl.fl_error     = fl_error_reg;

  // Error terms
  logic [PW:0]   free_plus_rel;
  logic [PW-1:0] in_flight;
  logic [PW-1:0] span_next;
  logic          overflow_err;
  logic          commit_err;
  logic          wrap_err;

  always_comb begin
    commit_head_next = commit_head_reg + PW'(fl.commit_cnt);
    tail_next        = tail_reg + PW'(rel_cnt);
    head_next        = head_reg;
    if (fl.flush) begin
      // Same-cycle commits are honoured by rewinding to the updated commit head.
      head_next = commit_head_next;
    end else if (grant) begin
      head_next = head_reg + PW'(alloc_cnt);
    end

    free_plus_rel = {1'b0, free_count} + (PW+1)'(rel_cnt);
    overflow_err  = free_plus_rel > (PW+1)'(DEPTH);

    // Ids allocated but not yet committed; committing more than that means
    // committing an id that was never handed out.
    in_flight  = head_reg - commit_head_reg;
    commit_err = PW'(fl.commit_cnt) > in_flight;

    // Tail may never lap the recoverable region starting at commit_head.
    span_next = tail_next - commit_head_next;
    wrap_err  = span_next > PW'(DEPTH);

    fl_error_next = fl_error_reg | overflow_err | commit_err | wrap_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg        <= '0;
      commit_head_reg <= '0;
      tail_reg        <= PW'(DEPTH);
      fl_error_reg    <= 1'b0;
    end else begin
      head_reg        <= head_next;
      commit_head_reg <= commit_head_next;
      tail_reg        <= tail_next;
      fl_error_reg    <= fl_error_next;
    end
  end

  // List contents need a reset image (ids ARF_NUM..PRF_NUM-1), so this is
  // register storage rather than block RAM; reads are combinational.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        fl_mem[j] <= PRF_WIDTH'(ARF_NUM + j);
      end
    end else begin
      for (int r = 0; r < REL_PORTS; r++) begin
        if (fl.rel_valid[r]) begin
          fl_mem[wr_idx[r]] <= fl.rel_prf_id[r*PRF_WIDTH +: PRF_WIDTH];
        end
      end
    end
  end
endmodule

// File: doc/prf_free_list_mp.md
Name: prf_free_list_mp

Overview:
Parametrised multi-port physical-register free list for the superscalar rename stage. It replaces the single-lane FL_NUM/FL_WIDTH free list.
- Supplies up to ALLOC_PORTS fresh PRF ids per cycle to rename.
- Accepts up to REL_PORTS retired T_old ids per cycle from the ROB.
- Keeps a speculative head and an architectural (commit) head. A pipeline flush restores the list in one cycle without a ROB walk.

Parameters:
PRF_NUM, 64, number of physical registers.
PRF_WIDTH, 6, PRF id width; must equal clog2(PRF_NUM).
ARF_NUM, 32, architectural registers; PRF 0..ARF_NUM-1 are mapped at reset.
ALLOC_PORTS, 2, rename lanes.
REL_PORTS, 2, retire lanes.
Derived: DEPTH = PRF_NUM-ARF_NUM (power of two); PW = clog2(DEPTH)+1 (pointer width, MSB = wrap bit).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
alloc_req  in  ALLOC_PORTS  per-lane request for a new PRF id
alloc_prf_id  out  ALLOC_PORTS*PRF_WIDTH  id per lane (lane i at bits [i*PRF_WIDTH +: PRF_WIDTH])
alloc_grant  out  1  all requested lanes served this cycle
commit_cnt  in  clog2(ALLOC_PORTS+1)  number of allocated ids retired this cycle
rel_valid  in  REL_PORTS  per-lane release valid
rel_prf_id  in  REL_PORTS*PRF_WIDTH  T_old ids being freed
flush  in  1  misprediction/exception recovery
free_count  out  PW  entries currently free (speculative view)
fl_error  out  1  sticky overflow/underflow/commit error

Behaviour:
- Storage: circular array fl_mem[DEPTH] of PRF_WIDTH. Pointers head, commit_head and tail are PW bits each. free_count = tail-head, mod 2^PW.
- Reset (asynchronous): fl_mem[j] = ARF_NUM+j; head = commit_head = 0; tail = DEPTH; fl_error = 0; free_count = DEPTH.
- Reset mid-operation discards all state immediately, independent of clk.
- Allocation:
  - k = popcount(alloc_req).
  - Each requested lane i receives fl_mem[head + (number of requested lanes below i)]. Ids are combinational from current state with zero-cycle latency.
  - Unrequested lanes drive 0.
  - alloc_grant = (k==0) | (free_count>=k), and is 0 while flush=1.
  - The grant is all-or-nothing: on grant, head += k at the clock edge. On no grant, head is unchanged and rename must stall.
- Release:
  - Valid lanes are compacted in lane order: the m-th valid lane writes fl_mem[tail+m].
  - tail += popcount(rel_valid).
  - Releases never bypass into same-cycle allocation: the grant uses free_count before the release.
- Commit: commit_head += commit_cnt.
- Flush:
  - head_next = commit_head + commit_cnt, i.e. same-cycle commits are honoured.
  - Allocation is suppressed that cycle.
  - Releases in the same cycle still update tail.
  - fl_mem contents are untouched; ids between commit_head and the old head become free again.
- Error conditions, each sets fl_error sticky until reset; state still updates with saturation disabled, and behaviour is undefined afterwards:
  - free_count + releases > DEPTH (overflow);
  - commit_head + commit_cnt passes head (commit of unallocated id);
  - tail wrapping past commit_head.
- Wrap-around: pointer arithmetic is modulo 2^PW; array index = pointer[PW-2:0]. Full is DEPTH free entries; empty is 0.
- PRF 0..ARF_NUM-1 appear only after being released.

Test Plan:
- Reset, then alloc_req=2'b11 -> ids 32,33, grant=1; next cycle free_count=30.
- alloc_req=2'b10 only -> lane1 gets 32, lane0 id=0, head+1; next request 2'b11 -> 33,34.
- 31 single allocations (free_count=1), then alloc_req=2'b11 -> grant=0, head unchanged. Same cycle rel_valid=2'b01 id=5 -> free_count=2 next cycle, but no grant in the release cycle.
- Allocate 6 ids (32..37), commit_cnt=2, flush with commit_cnt=1 in the same cycle -> head=3, free_count=29. Next allocation returns 35.
- Fill-drain wrap: 100 cycles random alloc/release with release=T_old scoreboard -> no duplicate ids outstanding, free_count matches model, fl_error=0.
- Release 2 ids while free_count=DEPTH -> fl_error=1 next cycle. Assert reset mid-cycle -> fl_error=0 and free_count=32 immediately.
